// File: rtl/airi5c_float_compare_minmax_pipe.sv
// Pipelined FEQ/FLT/FLE and FMIN/FMAX unit for the airi5c FPU.
// Operands are captured on load, classified/compared in stage 1 and resolved into results in stage 2.
module airi5c_float_compare_minmax_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     kill,
  input  logic                     load,
  input  logic                     op_eq,
  input  logic                     op_lt,
  input  logic                     op_le,
  input  logic                     op_min,
  input  logic                     op_max,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic [XLEN-1:0]          int_out,
  output logic [EXP_W+MAN_W:0]     float_out,
  output logic                     NV,
  output logic                     ready
);

  localparam int FLEN = 1 + EXP_W + MAN_W;
  localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {OP_EQ, OP_LT, OP_LE, OP_MIN, OP_MAX} op_e;

  logic            w_anyOp;
  op_e             w_decOp;
  logic            r_inValid;
  op_e             r_inOp;
  logic [FLEN-1:0] r_inA, r_inB;

  assign w_anyOp = op_eq | op_lt | op_le | op_min | op_max;

  always_comb begin
    w_decOp = OP_MAX;
    if (op_eq)       w_decOp = OP_EQ;
    else if (op_lt)  w_decOp = OP_LT;
    else if (op_le)  w_decOp = OP_LE;
    else if (op_min) w_decOp = OP_MIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inValid <= 1'b0;
      r_inOp    <= OP_EQ;
      r_inA     <= '0;
      r_inB     <= '0;
    end else if (kill) begin
      r_inValid <= 1'b0;
    end else begin
      r_inValid <= load & w_anyOp;
      if (load && w_anyOp) begin
        r_inOp <= w_decOp;
        r_inA  <= a;
        r_inB  <= b;
      end
    end
  end

  logic w_nanA, w_nanB, w_snanA, w_snanB, w_zeroA, w_zeroB;
  logic w_magLt, w_magEq, w_eqRaw, w_ltRaw, w_unord;

  assign w_nanA  = (&r_inA[FLEN-2 -: EXP_W]) & (|r_inA[MAN_W-1:0]);
  assign w_nanB  = (&r_inB[FLEN-2 -: EXP_W]) & (|r_inB[MAN_W-1:0]);
  assign w_snanA = w_nanA & ~r_inA[MAN_W-1];
  assign w_snanB = w_nanB & ~r_inB[MAN_W-1];
  assign w_zeroA = ~|r_inA[FLEN-2:0];
  assign w_zeroB = ~|r_inB[FLEN-2:0];
  assign w_magLt = r_inA[FLEN-2:0] < r_inB[FLEN-2:0];
  assign w_magEq = r_inA[FLEN-2:0] == r_inB[FLEN-2:0];
  assign w_unord = w_nanA | w_nanB;
  assign w_eqRaw = (r_inA == r_inB) | (w_zeroA & w_zeroB);

  // Sign-magnitude ordering; for two negatives the larger magnitude is the smaller value.
  always_comb begin
    w_ltRaw = 1'b0;
    case ({r_inA[FLEN-1], r_inB[FLEN-1]})
      2'b10:   w_ltRaw = ~(w_zeroA & w_zeroB);
      2'b00:   w_ltRaw = w_magLt;
      2'b11:   w_ltRaw = ~w_magLt & ~w_magEq;
      default: w_ltRaw = 1'b0;
    endcase
  end

  logic            r_s1Valid;
  op_e             r_s1Op;
  logic [FLEN-1:0] r_s1A, r_s1B;
  logic            r_s1Equal, r_s1Less;
  logic            r_s1NanA, r_s1NanB, r_s1SnanA, r_s1SnanB, r_s1ZeroA, r_s1ZeroB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Op    <= OP_EQ;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Equal <= 1'b0;
      r_s1Less  <= 1'b0;
      r_s1NanA  <= 1'b0;
      r_s1NanB  <= 1'b0;
      r_s1SnanA <= 1'b0;
      r_s1SnanB <= 1'b0;
      r_s1ZeroA <= 1'b0;
      r_s1ZeroB <= 1'b0;
    end else if (kill) begin
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= r_inValid;
      if (r_inValid) begin
        r_s1Op    <= r_inOp;
        r_s1A     <= r_inA;
        r_s1B     <= r_inB;
        r_s1Equal <= w_eqRaw & ~w_unord;
        r_s1Less  <= w_ltRaw & ~w_unord;
        r_s1NanA  <= w_nanA;
        r_s1NanB  <= w_nanB;
        r_s1SnanA <= w_snanA;
        r_s1SnanB <= w_snanB;
        r_s1ZeroA <= w_zeroA;
        r_s1ZeroB <= w_zeroB;
      end
    end
  end

  logic            w_y, w_nv, w_isMin;
  logic [FLEN-1:0] w_fltRes;

  assign w_isMin = (r_s1Op == OP_MIN);

  // Signed zeros compare equal, so min/max must pick by sign bit to return -0 / +0.
  always_comb begin
    w_y      = 1'b0;
    w_nv     = 1'b0;
    w_fltRes = '0;
    case (r_s1Op)
      OP_EQ: begin
        w_y  = r_s1Equal;
        w_nv = r_s1SnanA | r_s1SnanB;
      end
      OP_LT: begin
        w_y  = r_s1Less;
        w_nv = r_s1NanA | r_s1NanB;
      end
      OP_LE: begin
        w_y  = r_s1Less | r_s1Equal;
        w_nv = r_s1NanA | r_s1NanB;
      end
      default: begin
        w_nv = r_s1SnanA | r_s1SnanB;
        if (r_s1NanA && r_s1NanB)        w_fltRes = CANON_NAN;
        else if (r_s1NanA)               w_fltRes = r_s1B;
        else if (r_s1NanB)               w_fltRes = r_s1A;
        else if (r_s1ZeroA && r_s1ZeroB) w_fltRes = (r_s1A[FLEN-1] == w_isMin) ? r_s1A : r_s1B;
        else if (r_s1Less)               w_fltRes = w_isMin ? r_s1A : r_s1B;
        else                             w_fltRes = w_isMin ? r_s1B : r_s1A;
      end
    endcase
  end

  logic [XLEN-1:0] r_intOut;
  logic [FLEN-1:0] r_floatOut;
  logic            r_nv, r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_intOut   <= '0;
      r_floatOut <= '0;
      r_nv       <= 1'b0;
      r_ready    <= 1'b0;
    end else if (kill) begin
      r_intOut   <= '0;
      r_floatOut <= '0;
      r_nv       <= 1'b0;
      r_ready    <= 1'b0;
    end else if (r_s1Valid) begin
      r_intOut   <= {{(XLEN-1){1'b0}}, w_y};
      r_floatOut <= w_fltRes;
      r_nv       <= w_nv;
      r_ready    <= 1'b1;
    end else begin
      r_ready    <= 1'b0;
    end
  end

  assign int_out   = r_intOut;
  assign float_out = r_floatOut;
  assign NV        = r_nv;
  assign ready     = r_ready;

endmodule

// File: tb/tb_airi5c_float_compare_minmax_pipe.sv
// Directed self-checking bench for airi5c_float_compare_minmax_pipe (single and double formats).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_airi5c_float_compare_minmax_pipe;

  localparam int OP_EQ = 0, OP_LT = 1, OP_LE = 2, OP_MIN = 3, OP_MAX = 4, OP_NONE = 5;

  logic        clk = 1'b0;
  logic        reset, kill, load;
  logic        op_eq, op_lt, op_le, op_min, op_max;
  logic [31:0] a, b, int_out, float_out;
  logic        NV, ready;

  logic        load64, opEq64, opLt64, opLe64, opMin64, opMax64;
  logic [63:0] a64, b64, intOut64, floatOut64;
  logic        nv64, ready64;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  airi5c_float_compare_minmax_pipe #(.EXP_W(8), .MAN_W(23), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .kill(kill), .load(load),
    .op_eq(op_eq), .op_lt(op_lt), .op_le(op_le), .op_min(op_min), .op_max(op_max),
    .a(a), .b(b), .int_out(int_out), .float_out(float_out), .NV(NV), .ready(ready)
  );

  airi5c_float_compare_minmax_pipe #(.EXP_W(11), .MAN_W(52), .XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .kill(1'b0), .load(load64),
    .op_eq(opEq64), .op_lt(opLt64), .op_le(opLe64), .op_min(opMin64), .op_max(opMax64),
    .a(a64), .b(b64), .int_out(intOut64), .float_out(floatOut64), .NV(nv64), .ready(ready64)
  );

  task automatic driveOp(input int op, input logic [31:0] x, input logic [31:0] y);
    load   = 1'b1;
    op_eq  = (op == OP_EQ);
    op_lt  = (op == OP_LT);
    op_le  = (op == OP_LE);
    op_min = (op == OP_MIN);
    op_max = (op == OP_MAX);
    a      = x;
    b      = y;
  endtask

  task automatic idle();
    load = 1'b0; op_eq = 1'b0; op_lt = 1'b0; op_le = 1'b0; op_min = 1'b0; op_max = 1'b0;
  endtask

  // Issue one op and collect what appears three falling edges later, when its ready pulse is due.
  task automatic runOp(input int op, input logic [31:0] x, input logic [31:0] y,
                       output logic rdyEarly, output logic rdy,
                       output logic [31:0] io, output logic [31:0] fo, output logic nv);
    @(negedge clk); driveOp(op, x, y);
    @(negedge clk); idle(); rdyEarly = ready;
    @(negedge clk); rdyEarly = rdyEarly | ready;
    @(negedge clk); rdy = ready; io = int_out; fo = float_out; nv = NV;
  endtask

  task automatic test_reset();
    logic e, r, n;
    logic [31:0] io, fo;
    reset = 1'b1; kill = 1'b0; idle(); a = '0; b = '0;
    repeat (2) @(negedge clk);
    nChecks++; if ({ready, NV, int_out, float_out} !== '0) begin
      nFails++; $display("[TB] FAIL reset_outputs: got rdy=%b nv=%b int=%h flt=%h expected all 0", ready, NV, int_out, float_out);
    end
    reset = 1'b0;
    runOp(OP_MAX, 32'h3F800000, 32'h40000000, e, r, io, fo, n);
    nChecks++; if (fo !== 32'h40000000 || r !== 1'b1) begin
      nFails++; $display("[TB] FAIL pre_reset_max: got rdy=%b flt=%h expected 1/40000000", r, fo);
    end
    @(negedge clk); driveOp(OP_EQ, 32'h3F800000, 32'h3F800000);
    @(negedge clk); idle();
    #2 reset = 1'b1;
    #1;
    nChecks++; if ({ready, NV, int_out, float_out} !== '0) begin
      nFails++; $display("[TB] FAIL async_reset: got rdy=%b nv=%b int=%h flt=%h expected all 0", ready, NV, int_out, float_out);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nChecks++; if (ready !== 1'b0) begin
        nFails++; $display("[TB] FAIL lost_in_flight: got ready=%b expected 0 (cycle %0d)", ready, i);
      end
    end
    runOp(OP_EQ, 32'h3F800000, 32'h3F800000, e, r, io, fo, n);
    nChecks++; if (e !== 1'b0 || r !== 1'b1) begin
      nFails++; $display("[TB] FAIL eq_latency: got early=%b ready=%b expected 0/1", e, r);
    end
    nChecks++; if (io !== 32'd1 || fo !== 32'd0 || n !== 1'b0) begin
      nFails++; $display("[TB] FAIL eq_one: got int=%h flt=%h nv=%b expected 1/0/0", io, fo, n);
    end
    @(negedge clk);
    nChecks++; if (ready !== 1'b0) begin
      nFails++; $display("[TB] FAIL ready_single_pulse: got ready=%b expected 0", ready);
    end
  endtask

  task automatic test_ordering();
    int          vOp [12] = '{OP_EQ, OP_LT, OP_LE, OP_MIN, OP_MAX, OP_MAX, OP_MIN, OP_LT, OP_LE, OP_LT, OP_LT, OP_LE};
    logic [31:0] vA  [12] = '{32'h80000000, 32'hC0000000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h80000000,
                              32'h80000000, 32'h80000000, 32'h80000000, 32'hBF800000, 32'hC0000000, 32'h3F800000};
    logic [31:0] vB  [12] = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h00000000,
                              32'h00000000, 32'h00000000, 32'h00000000, 32'hC0000000, 32'hBF800000, 32'h3F800000};
    logic [31:0] vInt[12] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
    logic [31:0] vFlt[12] = '{0, 0, 0, 32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 0, 0, 0, 0, 0};
    logic e, r, n;
    logic [31:0] io, fo;
    for (int i = 0; i < 12; i++) begin
      runOp(vOp[i], vA[i], vB[i], e, r, io, fo, n);
      nChecks++; if (r !== 1'b1 || io !== vInt[i] || fo !== vFlt[i] || n !== 1'b0) begin
        nFails++; $display("[TB] FAIL order_%0d: got rdy=%b int=%h flt=%h nv=%b expected 1/%h/%h/0", i, r, io, fo, n, vInt[i], vFlt[i]);
      end
    end
  endtask

  task automatic test_nan();
    int          vOp [9] = '{OP_EQ, OP_LT, OP_LT, OP_EQ, OP_EQ, OP_MIN, OP_MAX, OP_MAX, OP_LE};
    logic [31:0] vA  [9] = '{32'h7FC00000, 32'h7FC00000, 32'h3F800000, 32'h7F800001, 32'h3F800000,
                             32'h7F800001, 32'h7FC00000, 32'h3F800000, 32'h7F800000};
    logic [31:0] vB  [9] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000,
                             32'h40400000, 32'hFFC00001, 32'h7FC00000, 32'h7F800000};
    logic [31:0] vInt[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] vFlt[9] = '{0, 0, 0, 0, 0, 32'h40400000, 32'h7FC00000, 32'h3F800000, 0};
    logic        vNv [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic e, r, n;
    logic [31:0] io, fo;
    for (int i = 0; i < 9; i++) begin
      runOp(vOp[i], vA[i], vB[i], e, r, io, fo, n);
      nChecks++; if (r !== 1'b1 || io !== vInt[i] || fo !== vFlt[i] || n !== vNv[i]) begin
        nFails++; $display("[TB] FAIL nan_%0d: got rdy=%b int=%h flt=%h nv=%b expected 1/%h/%h/%b", i, r, io, fo, n, vInt[i], vFlt[i], vNv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          sOp [2][5] = '{'{OP_EQ, OP_LT, OP_MIN, OP_LE, OP_MAX}, '{OP_LT, OP_LE, OP_NONE, OP_EQ, OP_MIN}};
    logic [31:0] sA  [2][5] = '{'{32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h40000000, 32'hC0000000},
                                '{32'hBF800000, 32'h80000000, 32'h12345678, 32'h7F800001, 32'h7F800001}};
    logic [31:0] sB  [2][5] = '{'{32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'hC0400000},
                                '{32'hC0000000, 32'h00000000, 32'h12345678, 32'h3F800000, 32'h40400000}};
    logic        sRdy[2][5] = '{'{1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
    logic [31:0] sInt[2][5] = '{'{1, 1, 0, 0, 0}, '{0, 1, 1, 0, 0}};
    logic [31:0] sFlt[2][5] = '{'{0, 0, 32'hC0000000, 0, 32'hC0000000}, '{0, 0, 0, 0, 32'h40400000}};
    logic        sNv [2][5] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1}};
    for (int bu = 0; bu < 2; bu++) begin
      repeat (3) @(negedge clk);
      for (int t = 0; t < 9; t++) begin
        @(negedge clk);
        if (t >= 3 && t < 8) begin
          nChecks++; if (ready !== sRdy[bu][t-3] || int_out !== sInt[bu][t-3] || float_out !== sFlt[bu][t-3] || NV !== sNv[bu][t-3]) begin
            nFails++; $display("[TB] FAIL b2b_%0d_%0d: got rdy=%b int=%h flt=%h nv=%b expected %b/%h/%h/%b", bu, t-3,
                               ready, int_out, float_out, NV, sRdy[bu][t-3], sInt[bu][t-3], sFlt[bu][t-3], sNv[bu][t-3]);
          end
        end else begin
          nChecks++; if (ready !== 1'b0) begin
            nFails++; $display("[TB] FAIL b2b_idle_%0d_%0d: got ready=%b expected 0", bu, t, ready);
          end
        end
        if (t < 5) driveOp(sOp[bu][t], sA[bu][t], sB[bu][t]);
        else       idle();
      end
    end
  endtask

  task automatic test_kill();
    @(negedge clk); driveOp(OP_LE, 32'h3F800000, 32'h40000000);
    @(negedge clk); driveOp(OP_EQ, 32'h3F800000, 32'h3F800000);
    @(negedge clk); driveOp(OP_LT, 32'hC0000000, 32'h3F800000); kill = 1'b1;
    @(negedge clk); kill = 1'b0; driveOp(OP_MAX, 32'hBF800000, 32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      nChecks++; if ({ready, NV, int_out, float_out} !== '0) begin
        nFails++; $display("[TB] FAIL kill_flush_%0d: got rdy=%b nv=%b int=%h flt=%h expected all 0", i, ready, NV, int_out, float_out);
      end
      @(negedge clk); idle();
    end
    nChecks++; if (ready !== 1'b1 || float_out !== 32'h3F800000 || int_out !== 32'd0 || NV !== 1'b0) begin
      nFails++; $display("[TB] FAIL after_kill: got rdy=%b int=%h flt=%h nv=%b expected 1/0/3f800000/0", ready, int_out, float_out, NV);
    end
  endtask

  task automatic test_double();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      load64 = 1'b1; opMin64 = (k == 0); opLt64 = (k == 1);
      a64 = (k == 0) ? 64'h7FF0000000000001 : 64'hBFF0000000000000;
      b64 = (k == 0) ? 64'h7FF4000000000000 : 64'h0000000000000001;
      @(negedge clk); load64 = 1'b0; opMin64 = 1'b0; opLt64 = 1'b0;
      repeat (2) @(negedge clk);
      if (k == 0) begin
        nChecks++; if (ready64 !== 1'b1 || floatOut64 !== 64'h7FF8000000000000 || nv64 !== 1'b1 || intOut64 !== 64'd0) begin
          nFails++; $display("[TB] FAIL dbl_min_snan: got rdy=%b flt=%h nv=%b int=%h expected 1/7ff8000000000000/1/0", ready64, floatOut64, nv64, intOut64);
        end
      end else begin
        nChecks++; if (ready64 !== 1'b1 || intOut64 !== 64'd1 || floatOut64 !== 64'd0 || nv64 !== 1'b0) begin
          nFails++; $display("[TB] FAIL dbl_lt: got rdy=%b int=%h flt=%h nv=%b expected 1/1/0/0", ready64, intOut64, floatOut64, nv64);
        end
      end
    end
  endtask

  initial begin
    load64 = 1'b0; opEq64 = 1'b0; opLt64 = 1'b0; opLe64 = 1'b0; opMin64 = 1'b0; opMax64 = 1'b0;
    a64 = '0; b64 = '0;
    test_reset();
    test_ordering();
    test_nan();
    test_back_to_back();
    test_kill();
    test_double();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
